// File: rtl/i2s_tx.sv
// I2S transmitter: 64 bclk per frame, 32-bit slots, 18-bit samples sent MSB-first after a one-bit delay.
// Requests a sample per channel once per frame and flags underrun when a slot reloads a stale sample.
module i2s_tx #(
    parameter int unsigned BCLK_HALF = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        gen_left_sample,
    output logic        gen_right_sample,
    input  logic        left_sample_rdy,
    input  logic [17:0] left_sample_in,
    input  logic        right_sample_rdy,
    input  logic [17:0] right_sample_in,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data,
    output logic        underrun
);

    logic [7:0]  bclk_cnt_q, bclk_cnt_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        lrclk_q, lrclk_d;
    logic        data_q, data_d;
    logic        gen_l_q, gen_l_d;
    logic        gen_r_q, gen_r_d;
    logic        underrun_q, underrun_d;
    logic [17:0] hold_l_q, hold_l_d;
    logic [17:0] hold_r_q, hold_r_d;
    logic [17:0] shift_l_q, shift_l_d;
    logic [17:0] shift_r_q, shift_r_d;
    logic        fresh_l_q, fresh_l_d;
    logic        fresh_r_q, fresh_r_d;

    logic        wrap;
    logic        fall;
    logic [5:0]  b;
    logic [4:0]  p;
    logic [4:0]  idx;
    logic [17:0] slot_src;

    // A *_sample_rdy pulse is accepted in any cycle and overwrites the holding register;
    // a load in the same cycle still takes the old holding value, and the new one stays fresh.
    always_comb begin
        wrap       = (bclk_cnt_q == 8'(BCLK_HALF - 1));
        fall       = wrap & bclk_q;
        b          = bit_cnt_q + 6'd1;
        p          = b[4:0];
        idx        = 5'd18 - p;
        slot_src   = b[5] ? shift_r_q : shift_l_q;

        bclk_cnt_d = wrap ? 8'd0 : bclk_cnt_q + 8'd1;
        bclk_d     = bclk_q ^ wrap;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        data_d     = data_q;
        gen_l_d    = 1'b0;
        gen_r_d    = 1'b0;
        underrun_d = 1'b0;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        fresh_l_d  = fresh_l_q;
        fresh_r_d  = fresh_r_q;
        hold_l_d   = left_sample_rdy  ? left_sample_in  : hold_l_q;
        hold_r_d   = right_sample_rdy ? right_sample_in : hold_r_q;

        if (fall) begin
            bit_cnt_d = b;
            lrclk_d   = b[5];
            data_d    = (p >= 5'd1 && p <= 5'd18) ? slot_src[idx] : 1'b0;
            if (b == 6'd0) begin
                shift_l_d  = hold_l_q;
                gen_r_d    = 1'b1;
                underrun_d = ~fresh_l_q;
                fresh_l_d  = 1'b0;
            end
            if (b == 6'd32) begin
                shift_r_d  = hold_r_q;
                gen_l_d    = 1'b1;
                underrun_d = ~fresh_r_q;
                fresh_r_d  = 1'b0;
            end
        end

        if (left_sample_rdy) begin
            fresh_l_d = 1'b1;
        end
        if (right_sample_rdy) begin
            fresh_r_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_cnt_q <= 8'd0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 6'd63;
            lrclk_q    <= 1'b0;
            data_q     <= 1'b0;
            gen_l_q    <= 1'b0;
            gen_r_q    <= 1'b0;
            underrun_q <= 1'b0;
            hold_l_q   <= 18'd0;
            hold_r_q   <= 18'd0;
            shift_l_q  <= 18'd0;
            shift_r_q  <= 18'd0;
            fresh_l_q  <= 1'b1;
            fresh_r_q  <= 1'b1;
        end else begin
            bclk_cnt_q <= bclk_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            data_q     <= data_d;
            gen_l_q    <= gen_l_d;
            gen_r_q    <= gen_r_d;
            underrun_q <= underrun_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            fresh_l_q  <= fresh_l_d;
            fresh_r_q  <= fresh_r_d;
        end
    end

    assign gen_left_sample  = gen_l_q;
    assign gen_right_sample = gen_r_q;
    assign i2s_bclk         = bclk_q;
    assign i2s_lrclk        = lrclk_q;
    assign i2s_data         = data_q;
    assign underrun         = underrun_q;

endmodule
